// File: rtl/adc_channel_scheduler.sv
// Scans NCH XADC channels over DRP on each eoc_in and keeps the latest 12-bit result per channel.
// Optional macro ADC_SCHED_AVG_EN stores a rounded 2-tap running average instead of the raw sample.
module adc_channel_scheduler #(
   parameter int unsigned NCH     = 13,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           enable,
   input  logic           eoc_in,
   output logic [6:0]     daddr,
   output logic           den,
   output logic           dwe,
   input  logic           drdy,
   input  logic [15:0]    do_in,
   input  logic [3:0]     rd_ch,
   output logic [11:0]    rd_data,
   output logic [NCH-1:0] valid,
   output logic           frame_done,
   output logic           busy,
   output logic           err
);

   localparam int unsigned WW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
   localparam logic [3:0]  LAST_CH   = 4'(NCH - 1);
   localparam logic [4:0]  NCH_W     = 5'(NCH);

   typedef enum logic [2:0] {StIdle, StIssue, StWaitRdy, StStore, StNext} state_t;

   state_t        state;
   logic [3:0]    ch;
   logic [WW-1:0] wait_cnt;
   logic [11:0]   sample;
   logic [11:0]   store_val;
   logic [11:0]   result [NCH];
   logic          unused_low_bits;

   // Channel 0 is VP/VN; auxiliary channels start at 7'h10.
   function automatic logic [6:0] ch_addr(input logic [3:0] c);
      return (c == 4'd0) ? 7'h03 : 7'h0f + {3'b000, c};
   endfunction

   assign dwe             = 1'b0;
   assign busy            = (state != StIdle);
   assign unused_low_bits = ^do_in[3:0];

`ifdef ADC_SCHED_AVG_EN
   logic [12:0] avg_sum;

   always_comb begin
      avg_sum   = {1'b0, result[ch]} + {1'b0, sample} + 13'd1;
      store_val = valid[ch] ? 12'(avg_sum >> 1) : sample;
   end
`else
   assign store_val = sample;
`endif

   always_ff @(posedge clk) begin
      den        <= 1'b0;
      frame_done <= 1'b0;
      if (rst) begin
         state    <= StIdle;
         ch       <= 4'd0;
         daddr    <= 7'h00;
         wait_cnt <= '0;
         sample   <= 12'h000;
         valid    <= '0;
         err      <= 1'b0;
         for (int i = 0; i < int'(NCH); i++) begin
            result[i] <= 12'h000;
         end
      end else begin
         unique case (state)
            StIdle: begin
               if (enable && eoc_in) begin
                  ch    <= 4'd0;
                  daddr <= ch_addr(4'd0);
                  den   <= 1'b1;
                  state <= StIssue;
               end
            end
            StIssue: begin
               wait_cnt <= '0;
               state    <= StWaitRdy;
            end
            StWaitRdy: begin
               if (drdy) begin
                  sample <= do_in[15:4];
                  state  <= StStore;
               end else if (wait_cnt == WAIT_LAST) begin
                  // Give up on this channel; its result and valid bit stay as they were.
                  err   <= 1'b1;
                  state <= StNext;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            StStore: begin
               result[ch] <= store_val;
               valid[ch]  <= 1'b1;
               state      <= StNext;
            end
            StNext: begin
               if (ch < LAST_CH) begin
                  ch    <= ch + 4'd1;
                  daddr <= ch_addr(ch + 4'd1);
                  den   <= 1'b1;
                  state <= StIssue;
               end else begin
                  frame_done <= 1'b1;
                  state      <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   // Read port samples the array before this edge's store lands (read-before-write).
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data <= 12'h000;
      end else if ({1'b0, rd_ch} < NCH_W) begin
         rd_data <= result[rd_ch];
      end else begin
         rd_data <= 12'h000;
      end
   end

endmodule

// File: doc/adc_channel_scheduler.md
ADC_CHANNEL_SCHEDULER -- requirements
Module: adc_channel_scheduler

Interface
REQ-001 The block SHALL have these parameters:
- NCH, 13, number of scanned channels (max 16).
- TIMEOUT, 255, maximum cycles to wait for drdy.
REQ-002 The block SHALL have these ports:
- clk  in  1  system clock (100 MHz domain); sole clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  scanning allowed while high.
- eoc_in  in  1  ADC end-of-conversion pulse; starts a frame.
- daddr  out  7  DRP address.
- den  out  1  DRP enable, 1-cycle pulse.
- dwe  out  1  DRP write enable; constant 0.
- drdy  in  1  DRP read-data valid.
- do_in  in  16  DRP read data.
- rd_ch  in  4  consumer channel select.
- rd_data  out  12  stored result of rd_ch.
- valid  out  NCH  per-channel "result captured since reset".
- frame_done  out  1  1-cycle pulse after the last channel is stored.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky flag: a drdy timeout occurred.

Function
REQ-003 The address map SHALL be: channel 0 -> 7'h03 (VP/VN); channel k (1..NCH-1) -> 7'h10 + (k-1).
REQ-004 The FSM SHALL have states IDLE, ISSUE, WAIT_RDY, STORE and NEXT.
REQ-005 IDLE SHALL move to ISSUE when enable=1 and eoc_in=1 in the same cycle; the channel index is cleared to 0 on this transition.
REQ-006 ISSUE SHALL drive den=1 for exactly one cycle with daddr set to the mapped address, then go to WAIT_RDY.
REQ-007 WAIT_RDY SHALL go to STORE on drdy=1.
REQ-008 A wait counter SHALL run in WAIT_RDY; if drdy is still low after TIMEOUT cycles, the block SHALL set err, leave the stored value and valid bit unchanged, and go to NEXT.
REQ-009 STORE SHALL write do_in[15:4] (captured when drdy=1) into register[ch], set valid[ch], and go to NEXT.
REQ-010 NEXT behaviour:
- If ch < NCH-1: increment ch and go to ISSUE.
- Otherwise: pulse frame_done for one cycle and go to IDLE.
REQ-011 An eoc_in pulse arriving while busy=1 SHALL be ignored; it is not queued.
REQ-012 Deasserting enable mid-frame SHALL NOT abort the frame; enable is sampled only in IDLE.
REQ-013 drdy arriving outside WAIT_RDY SHALL be ignored.
REQ-014 rd_data SHALL be registered: it equals register[rd_ch] one cycle after rd_ch is presented.
REQ-015 If rd_ch >= NCH, rd_data SHALL be 12'h000.
REQ-016 When a STORE to channel ch and a read of ch fall in the same cycle, rd_data on the next cycle SHALL show the old value (read-before-write).
REQ-017 One frame with no timeouts SHALL take exactly 4*NCH cycles from the IDLE exit to the frame_done pulse, assuming drdy returns 1 cycle after den.

Reset
REQ-018 On rst=1 at a clk edge, the block SHALL reach:
- state IDLE, ch=0;
- den=0, daddr=0, dwe=0;
- all result registers 0, valid=0;
- rd_data=0, frame_done=0, busy=0, err=0.
REQ-019 Reset asserted mid-frame SHALL abandon the transaction; a drdy returning after reset SHALL be ignored.

Configuration
REQ-020 The macro ADC_SCHED_AVG_EN SHALL select the store behaviour:
- Defined: STORE writes (register[ch] + sample + 1) >> 1, computed 13 bits wide; the first sample after reset (valid[ch]=0) is written directly.
- Undefined: STORE writes the raw sample, and no adder is synthesized.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset, then enable=1, eoc_in pulse, drdy 1 cycle after each den, do_in=16'hABC0 for all channels -> 13 den pulses at addresses 03,10..1B; frame_done pulse after 52 cycles; rd_ch=5 returns 12'hABC; valid=13'h1FFF.
- drdy withheld on channel 3 -> err=1 after 255 wait cycles; valid[3]=0; frame completes; frame_done still pulses.
- eoc_in pulsed during a frame -> no second frame starts; after frame_done, IDLE waits for the next eoc_in.
- rst asserted during WAIT_RDY of channel 7 -> all outputs at reset values next cycle; a late drdy changes nothing.
- rd_ch=14 -> rd_data=0; same-cycle STORE and read of channel 2 -> old value returned, new value on the following read.
- With ADC_SCHED_AVG_EN: samples 12'h100 then 12'h200 on channel 0 -> stored 12'h180.
